// File: rtl/mux_scan_pkg.sv
// mux_scan shared definitions: FSM state encodings and mux select
// index constants (SEL_U..SEL_X name the four mux data inputs).
package mux_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_U = 2'd0;
    localparam logic [1:0] SEL_V = 2'd1;
    localparam logic [1:0] SEL_W = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

endpackage

// File: rtl/mux_scan_dwell_counter.sv
// dwell_counter: rate divider that counts 0..DWELL-1 while en is high.
// Ports: clock, reset (async, active-high), clear (sync zero),
//        en (count enable), last (cnt == DWELL-1 while en).
module dwell_counter #(
    parameter int DWELL = 4,
    parameter int CW    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam logic [CW-1:0] TOP = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign last = en && (cnt == TOP);

    // Wraps to zero on its own at the end of each dwell period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || last) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// mux_scan: steps a 4-to-1 mux select through 0..3, samples the mux
// output for each select and publishes the 4-bit word with a valid pulse.
// Ports: clock, reset (async, active-high), start, continuous, m (mux out),
//        sel (mux select), data (last scan), valid (1-cycle), busy.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       m,
    output logic [1:0] sel,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy
);

    state_t     state;
    state_t     state_nx;
    logic       in_drive;
    logic       last;
    logic [2:0] shadow;

    assign in_drive = (state == S_DRIVE);

    // Counter is held at zero outside DRIVE so every scan starts fresh.
    dwell_counter #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (!in_drive),
        .en    (in_drive),
        .last  (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (last && sel == SEL_X) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = continuous ? S_DRIVE : S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= (state_nx == S_DONE);
            busy  <= (state_nx != S_IDLE);
        end
    end

    // The fourth sample bypasses shadow straight into data, so sel
    // stays at 3 through DONE and only wraps to 0 on leaving it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel    <= SEL_U;
            shadow <= '0;
            data   <= '0;
        end else begin
            unique case (state)
                S_DRIVE: begin
                    if (last) begin
                        unique case (sel)
                            SEL_U: shadow[0] <= m;
                            SEL_V: shadow[1] <= m;
                            SEL_W: shadow[2] <= m;
                            SEL_X: data <= {m, shadow};
                        endcase
                        if (sel != SEL_X) begin
                            sel <= sel + 2'd1;
                        end
                    end
                end
                default: begin
                    sel <= SEL_U;
                end
            endcase
        end
    end

endmodule
